// File: rtl/wb_pkg.sv
// Shared types for the Wishbone burst master: FSM encoding,
// completion status codes and a constant clog2 helper.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WDAT = 2'd1,
    ST_REQ  = 2'd2,
    ST_DONE = 2'd3
  } wb_state_e;

  localparam logic [1:0] STS_OK  = 2'b00;
  localparam logic [1:0] STS_ERR = 2'b01;
  localparam logic [1:0] STS_TMO = 2'b10;
  localparam logic [1:0] STS_RTY = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_timeout.sv
// Stall counter: hit_o fires on the TIMEOUT-th consecutive
// cycle with en_i high; any gap in en_i clears the count.
module wb_timeout
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int CW =
    (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = en_i ? cnt_q + 1'b1 : '0;
  end

  assign hit_o = en_i && (int'(cnt_q) == TIMEOUT - 1);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wishbone_burst_master.sv
// Wishbone classic burst master with per-beat retry and error abort.
// Stall timeout is built only with WB_BURST_MASTER_TIMEOUT_EN defined.
module wishbone_burst_master
  import wb_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16,
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_we_i,
  input  logic [AW-1:0]                 cmd_adr_i,
  input  logic [DW/8-1:0]               cmd_sel_i,
  input  logic [clog2(MAX_BURST)-1:0]   cmd_len_i,
  input  logic                          wdat_valid_i,
  output logic                          wdat_ready_o,
  input  logic [DW-1:0]                 wdat_i,
  output logic                          rdat_valid_o,
  output logic [DW-1:0]                 rdat_o,
  output logic                          done_o,
  output logic [1:0]                    sts_o,
  output logic [AW-1:0]                 adr_o,
  output logic [DW-1:0]                 dat_o,
  input  logic [DW-1:0]                 dat_i,
  output logic                          we_o,
  output logic                          stb_o,
  output logic                          cyc_o,
  output logic [DW/8-1:0]               sel_o,
  input  logic                          ack_i,
  input  logic                          err_i,
  input  logic                          rty_i
);

  localparam int LW = clog2(MAX_BURST);
  localparam int SW = DW / 8;
  localparam int RW =
    (clog2(RETRY_MAX + 1) > 0) ? clog2(RETRY_MAX + 1) : 1;

  wb_state_e     state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [LW-1:0] left_q, left_d;
  logic [RW-1:0] rty_q, rty_d;
  logic [1:0]    sts_q, sts_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          rdy_q, rdy_d;
  logic          wrdy_q, wrdy_d;
  logic          rval_q, rval_d;
  logic          done_q, done_d;
  logic          fin;
  logic [1:0]    fin_sts;
  logic          tmo_hit;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  logic tmo_en;

  assign tmo_en = (state_q == ST_REQ) && stb_q
               && !(ack_i || err_i || rty_i);

  wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (tmo_en),
    .hit_o   (tmo_hit)
  );
`else
  logic unused_tmo;

  assign unused_tmo = ^TIMEOUT;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdat_d  = rdat_q;
    sel_d   = sel_q;
    left_d  = left_q;
    rty_d   = rty_q;
    sts_d   = sts_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    rdy_d   = rdy_q;
    wrdy_d  = wrdy_q;
    rval_d  = 1'b0;
    done_d  = 1'b0;
    fin     = 1'b0;
    fin_sts = STS_OK;
    unique case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        if (cmd_valid_i && rdy_q) begin
          adr_d  = cmd_adr_i;
          sel_d  = cmd_sel_i;
          we_d   = cmd_we_i;
          left_d = cmd_len_i;
          rty_d  = '0;
          cyc_d  = 1'b1;
          rdy_d  = 1'b0;
          if (cmd_we_i) begin
            state_d = ST_WDAT;
            wrdy_d  = 1'b1;
          end else begin
            state_d = ST_REQ;
            stb_d   = 1'b1;
          end
        end
      end
      ST_WDAT: begin
        if (wdat_valid_i && wrdy_q) begin
          dat_d   = wdat_i;
          wrdy_d  = 1'b0;
          stb_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // stb_q low here means the one-cycle gap after a retry
        if (!stb_q) begin
          stb_d = 1'b1;
        end else if (err_i) begin
          fin     = 1'b1;
          fin_sts = STS_ERR;
        end else if (rty_i) begin
          if (int'(rty_q) >= RETRY_MAX) begin
            fin     = 1'b1;
            fin_sts = STS_RTY;
          end else begin
            rty_d = rty_q + 1'b1;
            stb_d = 1'b0;
          end
        end else if (ack_i) begin
          rty_d = '0;
          adr_d = adr_q + AW'(SW);
          if (!we_q) begin
            rdat_d = dat_i;
            rval_d = 1'b1;
          end
          if (left_q == '0) begin
            fin = 1'b1;
          end else begin
            left_d = left_q - 1'b1;
            if (we_q) begin
              stb_d   = 1'b0;
              wrdy_d  = 1'b1;
              state_d = ST_WDAT;
            end
          end
        end else if (tmo_hit) begin
          fin     = 1'b1;
          fin_sts = STS_TMO;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
      end
    endcase
    if (fin) begin
      state_d = ST_DONE;
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      wrdy_d  = 1'b0;
      done_d  = 1'b1;
      sts_d   = fin_sts;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      left_q  <= '0;
      rty_q   <= '0;
      sts_q   <= STS_OK;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      rdy_q   <= 1'b0;
      wrdy_q  <= 1'b0;
      rval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdat_q  <= rdat_d;
      sel_q   <= sel_d;
      left_q  <= left_d;
      rty_q   <= rty_d;
      sts_q   <= sts_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      rdy_q   <= rdy_d;
      wrdy_q  <= wrdy_d;
      rval_q  <= rval_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready_o  = rdy_q;
  assign wdat_ready_o = wrdy_q;
  assign rdat_valid_o = rval_q;
  assign rdat_o       = rdat_q;
  assign done_o       = done_q;
  assign sts_o        = sts_q;
  assign adr_o        = adr_q;
  assign dat_o        = dat_q;
  assign we_o         = we_q;
  assign stb_o        = stb_q;
  assign cyc_o        = cyc_q;
  assign sel_o        = sel_q;

endmodule

// File: doc/wishbone_burst_master.md
WISHBONE_BURST_MASTER -- requirements
Module: wishbone_burst_master

Interface
REQ-001 Parameters SHALL be: AW, default 32, address width; DW, default 32, data width, a multiple of 8; MAX_BURST, default 16, a power of 2; RETRY_MAX, default 3, retries per beat; TIMEOUT, default 255, cycles.
REQ-002 Ports SHALL be:
- clk_i  in  1  single clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- cmd_valid_i/cmd_ready_o  in/out  1  command handshake.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  AW  start byte address.
- cmd_sel_i  in  DW/8  byte select, applied to all beats.
- cmd_len_i  in  clog2(MAX_BURST)  beats minus 1.
- wdat_valid_i/wdat_ready_o  in/out  1  write-data handshake.
- wdat_i  in  DW  write beat.
- rdat_valid_o  out  1  read beat valid, no backpressure.
- rdat_o  out  DW  read beat.
- done_o  out  1  one-cycle completion pulse.
- sts_o  out  2  completion status: 00 ok, 01 err_i, 10 timeout, 11 retries exhausted.
- adr_o  out  AW; dat_o  out  DW; dat_i  in  DW; we_o, stb_o, cyc_o  out  1; sel_o  out  DW/8; ack_i, err_i, rty_i  in  1  Wishbone classic master.

Function
REQ-003 States SHALL be IDLE, WDAT, REQ and DONE.
REQ-004 cmd_ready_o SHALL be high only in IDLE; accepting a command SHALL register adr, sel, we and len, load the beat counter, and go to WDAT (write) or REQ (read).
REQ-005 WDAT SHALL hold cyc_o=1 and stb_o=0 with wdat_ready_o=1; a wdat handshake SHALL latch dat_o and go to REQ on the next cycle.
REQ-006 REQ SHALL drive cyc_o=stb_o=1 until exactly one of ack_i, err_i or rty_i is sampled high.
REQ-007 On ack_i, adr_o SHALL advance by DW/8 modulo 2^AW. If the last beat is done, go to DONE; otherwise go to WDAT (write) or stay in REQ (read) with stb_o held.
REQ-008 On a read ack, rdat_o SHALL equal dat_i and rdat_valid_o SHALL pulse on the following cycle (latency 1).
REQ-009 Priority for simultaneous responses SHALL be err_i > rty_i > ack_i.
REQ-010 On err_i, stb_o and cyc_o SHALL drop on the next cycle, remaining beats SHALL be abandoned, and sts_o SHALL be 01.
REQ-011 On rty_i, stb_o SHALL drop for one cycle and the same beat SHALL be reissued with the same adr_o and dat_o; when the per-beat retry count exceeds RETRY_MAX, the burst SHALL abort with sts_o=11.
REQ-012 The retry count SHALL clear on every ack_i.
REQ-013 DONE SHALL last one cycle with done_o=1, cyc_o=0 and sts_o valid, then return to IDLE; sts_o SHALL hold until the next done_o.
REQ-014 cmd_len_i=0 SHALL produce one beat; cmd_len_i=MAX_BURST-1 SHALL produce MAX_BURST beats.
REQ-015 we_o and sel_o SHALL be stable for the whole cycle in which cyc_o is high.

Reset
REQ-016 While rst_n_i=0, all outputs SHALL be 0 and the state SHALL be IDLE, with cmd_ready_o reading 1 one cycle after deassertion.
REQ-017 Reset mid-burst SHALL drop cyc_o and stb_o immediately, with no done_o pulse.

Configuration
REQ-018 With WB_BURST_MASTER_TIMEOUT_EN defined, a counter SHALL count REQ cycles with stb_o=1 and no response, clearing on any response. When the counter reaches TIMEOUT, the burst SHALL abort as in REQ-010 with sts_o=10.
REQ-019 Without the macro, no counter logic SHALL exist, the block SHALL wait indefinitely, and sts_o=10 SHALL never occur.

Structure
REQ-020 A shared package wb_pkg SHALL hold the state encoding, the sts_o codes and a clog2 helper.
REQ-021 The timeout counter SHALL be sub-module wb_timeout, instantiated only under the macro.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Read burst, adr 0x100, len 3, slave acks every cycle -> adr_o 0x100/104/108/10C, four rdat pulses, done_o with sts 00.
- Write burst, len 1, wdat_valid delayed 3 cycles -> stb_o low while waiting, cyc_o held, two acked beats.
- rty_i on beat 0 with RETRY_MAX=3 -> same adr reissued; a 4th rty gives sts 11.
- err_i and ack_i together on beat 2 of a len-7 burst -> abort, sts 01, cyc_o low next cycle.
- Macro on, TIMEOUT=8, slave silent -> abort after 8 stb cycles, sts 10.
- adr 0xFFFFFFFC, len 1 -> second beat at 0x00000000; rst_n_i low mid-burst -> cyc_o=0 immediately.
